// File: rtl/yf_pkg.sv
// Shared definitions for the yfcpu core and its program loader.
package yf_pkg;

    localparam int im_size = 8;
    localparam int rf_size = 4;
    localparam int iw_size = 16;

    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_LRI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_SUM  = 3'd4,
        ST_RUN  = 3'd5,
        ST_ERR  = 3'd6
    } ld_state_e;

endpackage

// File: rtl/yf_prog_loader.sv
// Byte-serial framed image loader: SYNC, LEN, 2*LEN payload bytes (high first), SUM.
// Writes assembled words into instruction memory and gates the core's reset.
module yf_prog_loader #(
    parameter int im_size   = yf_pkg::im_size,
    parameter int iw_size   = yf_pkg::iw_size,
    parameter bit BOOT_HOLD = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               imem_we,
    output logic [im_size-1:0] imem_addr,
    output logic [iw_size-1:0] imem_wdata,
    output logic               cpu_rst,
    output logic               load_done,
    output logic               load_err,
    output logic [im_size:0]   words_loaded
);

    localparam logic [2:0] S_IDLE = yf_pkg::ST_IDLE;
    localparam logic [2:0] S_LEN  = yf_pkg::ST_LEN;
    localparam logic [2:0] S_HI   = yf_pkg::ST_HI;
    localparam logic [2:0] S_LO   = yf_pkg::ST_LO;
    localparam logic [2:0] S_SUM  = yf_pkg::ST_SUM;
    localparam logic [2:0] S_RUN  = yf_pkg::ST_RUN;
    localparam logic [2:0] S_ERR  = yf_pkg::ST_ERR;

    localparam logic [9:0]     MAX_WORDS = 10'(1 << im_size);
    localparam logic [im_size:0] WL_ONE  = {{im_size{1'b0}}, 1'b1};

    logic [2:0]         state_reg, state_next;
    logic [9:0]         len_reg, len_next;
    logic [7:0]         hi_reg, hi_next;
    logic [7:0]         sum_reg, sum_next;
    logic               ready_reg;
    logic               we_reg, we_next;
    logic [im_size-1:0] addr_reg, addr_next;
    logic [iw_size-1:0] wdata_reg, wdata_next;
    logic               crst_reg, crst_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
    logic [im_size:0]   wl_reg, wl_next;

    logic       accept;
    logic [9:0] len_eff;
    logic [9:0] wl_inc;

    assign accept  = in_valid && ready_reg;
    // LEN of zero encodes a full 256-word image
    assign len_eff = (in_data == 8'h00) ? 10'd256 : {2'b00, in_data};
    assign wl_inc  = 10'(wl_reg) + 10'd1;

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        hi_next    = hi_reg;
        sum_next   = sum_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        crst_next  = crst_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
        wl_next    = wl_reg;

        case (state_reg)
            S_IDLE, S_RUN, S_ERR: begin
                if (accept && in_data == yf_pkg::SYNC_BYTE) begin
                    state_next = S_LEN;
                    crst_next  = 1'b1;
                    err_next   = 1'b0;
                    wl_next    = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    sum_next  = 8'h00;
                    addr_next = '0;
                    if (len_eff > MAX_WORDS) begin
                        state_next = S_ERR;
                        err_next   = 1'b1;
                    end else begin
                        len_next   = len_eff;
                        state_next = S_HI;
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_next    = in_data;
                    sum_next   = sum_reg + in_data;
                    state_next = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    we_next    = 1'b1;
                    wdata_next = iw_size'({hi_reg, in_data});
                    addr_next  = wl_reg[im_size-1:0];
                    wl_next    = wl_reg + WL_ONE;
                    sum_next   = sum_reg + in_data;
                    state_next = (wl_inc == len_reg) ? S_SUM : S_HI;
                end
            end
            S_SUM: begin
                if (accept) begin
                    if (in_data == sum_reg) begin
                        state_next = S_RUN;
                        crst_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = S_ERR;
                        err_next   = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            len_reg   <= '0;
            hi_reg    <= '0;
            sum_reg   <= '0;
            ready_reg <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            crst_reg  <= BOOT_HOLD;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            wl_reg    <= '0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            hi_reg    <= hi_next;
            sum_reg   <= sum_next;
            ready_reg <= 1'b1;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            crst_reg  <= crst_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            wl_reg    <= wl_next;
        end
    end

    assign in_ready     = ready_reg;
    assign imem_we      = we_reg;
    assign imem_addr    = addr_reg;
    assign imem_wdata   = wdata_reg;
    assign cpu_rst      = crst_reg;
    assign load_done    = done_reg;
    assign load_err     = err_reg;
    assign words_loaded = wl_reg;

endmodule

// File: tb/tb_yf_prog_loader.sv
// Randomized scoreboard bench for yf_prog_loader: a full-size instance and a
// 4-word instance that exercises the oversize-LEN rejection.
module tb_yf_prog_loader;

    typedef struct {
        int dut;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int dut;
        int kind;   // 1 = load_done, 2 = load_err rise
        int words;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0]  din_a = 8'h00, din_b = 8'h00;
    logic        vin_a = 1'b0,  vin_b = 1'b0;
    logic        rdy_a, rdy_b, we_a, we_b, crst_a, crst_b;
    logic        done_a, done_b, err_a, err_b;
    logic [7:0]  addr_a;
    logic [1:0]  addr_b;
    logic [15:0] wdata_a, wdata_b;
    logic [8:0]  wl_a;
    logic [2:0]  wl_b;

    int n_checks = 0;
    int n_fail   = 0;

    wr_t exp_wr_q[$];
    ev_t exp_ev_q[$];
    logic [15:0] wbuf [0:255];
    bit done_prev [2];
    bit err_prev  [2];

    always #5 clk = ~clk;

    yf_prog_loader #(.im_size(8), .iw_size(16), .BOOT_HOLD(1'b0)) u_a (
        .clk(clk), .rst(rst), .in_data(din_a), .in_valid(vin_a), .in_ready(rdy_a),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a), .cpu_rst(crst_a),
        .load_done(done_a), .load_err(err_a), .words_loaded(wl_a)
    );

    yf_prog_loader #(.im_size(2), .iw_size(16), .BOOT_HOLD(1'b1)) u_b (
        .clk(clk), .rst(rst), .in_data(din_b), .in_valid(vin_b), .in_ready(rdy_b),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b), .cpu_rst(crst_b),
        .load_done(done_b), .load_err(err_b), .words_loaded(wl_b)
    );

    function automatic int f_rdy(input int d);   return d == 0 ? int'(rdy_a)  : int'(rdy_b);  endfunction
    function automatic int f_we(input int d);    return d == 0 ? int'(we_a)   : int'(we_b);   endfunction
    function automatic int f_crst(input int d);  return d == 0 ? int'(crst_a) : int'(crst_b); endfunction
    function automatic int f_done(input int d);  return d == 0 ? int'(done_a) : int'(done_b); endfunction
    function automatic int f_err(input int d);   return d == 0 ? int'(err_a)  : int'(err_b);  endfunction
    function automatic int f_addr(input int d);  return d == 0 ? int'(addr_a) : int'(addr_b); endfunction
    function automatic int f_wdata(input int d); return d == 0 ? int'(wdata_a) : int'(wdata_b); endfunction
    function automatic int f_wl(input int d);    return d == 0 ? int'(wl_a)   : int'(wl_b);   endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic send_byte(input int d, input logic [7:0] b);
        int guard;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
        if (d == 0) begin din_a = b; vin_a = 1'b1; end
        else        begin din_b = b; vin_b = 1'b1; end
        guard = 0;
        while (f_rdy(d) == 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", f_rdy(d), 1);
        @(posedge clk); #1;
        $display("dut%0d byte 0x%02h accepted", d, b);
        if (d == 0) vin_a = 1'b0;
        else        vin_b = 1'b0;
    endtask

    // Reference: frame built from wbuf; expectations derived from the frame rules.
    task automatic send_frame(input int d, input int len_byte, input bit bad);
        int eff, cap;
        logic [7:0] sum, sb;
        eff = (len_byte == 0) ? 256 : len_byte;
        cap = (d == 0) ? 256 : 4;
        send_byte(d, 8'hA5);
        chk("sync_cpu_rst", f_crst(d), 1);
        chk("sync_clr_err", f_err(d), 0);
        chk("sync_clr_words", f_wl(d), 0);
        if (eff > cap) begin
            exp_ev_q.push_back('{d, 2, 0});
            send_byte(d, 8'(len_byte));
            chk("len_err", f_err(d), 1);
            chk("len_err_no_we", f_we(d), 0);
            @(posedge clk); #1;
            chk("len_err_no_we_later", f_we(d), 0);
            chk("len_err_cpu_rst", f_crst(d), 1);
            $display("dut%0d frame len=%0d rejected as oversize", d, eff);
            return;
        end
        send_byte(d, 8'(len_byte));
        sum = 8'h00;
        for (int i = 0; i < eff; i++) begin
            exp_wr_q.push_back('{d, i, int'(wbuf[i])});
            send_byte(d, wbuf[i][15:8]);
            send_byte(d, wbuf[i][7:0]);
            sum = sum + wbuf[i][15:8] + wbuf[i][7:0];
            chk("wr_strobe", f_we(d), 1);
            chk("wr_count", f_wl(d), i + 1);
        end
        sb = bad ? sum - 8'h01 : sum;
        exp_ev_q.push_back('{d, bad ? 2 : 1, eff});
        send_byte(d, sb);
        if (!bad) begin
            chk("done_pulse", f_done(d), 1);
            chk("done_cpu_rst", f_crst(d), 0);
            chk("done_words", f_wl(d), eff);
            @(posedge clk); #1;
            chk("done_one_cycle", f_done(d), 0);
        end else begin
            chk("bad_sum_err", f_err(d), 1);
            chk("bad_sum_cpu_rst", f_crst(d), 1);
            chk("bad_sum_no_done", f_done(d), 0);
        end
        $display("dut%0d frame len=%0d sum=0x%02h sent=0x%02h %s", d, eff, sum, sb, bad ? "bad" : "good");
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (f_we(d) != 0) begin
                    if (exp_wr_q.size() == 0) begin
                        chk("unexpected_write", f_addr(d), -1);
                    end else begin
                        wr_t w;
                        w = exp_wr_q.pop_front();
                        chk("wr_dut", d, w.dut);
                        chk("wr_addr", f_addr(d), w.addr);
                        chk("wr_data", f_wdata(d), w.data);
                        chk("wr_under_cpu_rst", f_crst(d), 1);
                        $display("dut%0d write addr=%0d data=0x%04h", d, f_addr(d), f_wdata(d));
                    end
                end
                if (f_done(d) != 0) begin
                    if (done_prev[d]) chk("done_width", 2, 1);
                    if (exp_ev_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        ev_t e;
                        e = exp_ev_q.pop_front();
                        chk("done_dut", d, e.dut);
                        chk("done_kind", 1, e.kind);
                        chk("done_words_mon", f_wl(d), e.words);
                    end
                end
                if (f_err(d) != 0 && !err_prev[d]) begin
                    if (exp_ev_q.size() == 0) begin
                        chk("unexpected_err", 2, 0);
                    end else begin
                        ev_t e;
                        e = exp_ev_q.pop_front();
                        chk("err_dut", d, e.dut);
                        chk("err_kind", 2, e.kind);
                    end
                end
                done_prev[d] <= (f_done(d) != 0);
                err_prev[d]  <= (f_err(d) != 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        bit bad;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", int'(rdy_a), 0);
        chk("rst_ready_b", int'(rdy_b), 0);
        chk("rst_we_a", int'(we_a), 0);
        chk("rst_done_a", int'(done_a), 0);
        chk("rst_err_a", int'(err_a), 0);
        chk("rst_addr_a", int'(addr_a), 0);
        chk("rst_wdata_a", int'(wdata_a), 0);
        chk("rst_words_a", int'(wl_a), 0);
        chk("rst_cpu_rst_a", int'(crst_a), 0);
        chk("rst_cpu_rst_b", int'(crst_b), 1);
        rst = 1'b0;

        // stray bytes in idle
        send_byte(0, 8'h00);
        send_byte(0, 8'hFF);
        send_byte(0, 8'h3C);
        @(posedge clk); #1;
        chk("stray_cpu_rst", int'(crst_a), 0);
        chk("stray_words", int'(wl_a), 0);
        chk("stray_err", int'(err_a), 0);

        wbuf[0] = 16'h1241;
        wbuf[1] = 16'h1412;
        send_frame(0, 2, 1'b0);
        send_frame(0, 2, 1'b1);

        wbuf[0] = 16'hA5A5;
        send_frame(0, 1, 1'b0);

        // reset after first payload word
        send_byte(0, 8'hA5);
        send_byte(0, 8'h03);
        exp_wr_q.push_back('{0, 0, 16'h2233});
        send_byte(0, 8'h22);
        send_byte(0, 8'h33);
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_cpu_rst_a", int'(crst_a), 0);
        chk("midrst_cpu_rst_b", int'(crst_b), 1);
        chk("midrst_words", int'(wl_a), 0);
        chk("midrst_ready", int'(rdy_a), 0);
        wbuf[0] = 16'h4567;
        wbuf[1] = 16'h89AB;
        send_frame(0, 2, 1'b0);

        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                logic [31:0] r;
                r = $urandom;
                wbuf[i] = ($urandom_range(0, 3) == 0) ? 16'hA5A5 : r[15:0];
            end
            bad = ($urandom_range(0, 3) == 0);
            send_frame(0, len, bad);
        end

        for (int i = 0; i < 256; i++) begin
            logic [31:0] r;
            r = $urandom;
            wbuf[i] = r[15:0];
        end
        send_frame(0, 0, 1'b0);

        // small instance: capacity 4 words
        send_frame(1, 5, 1'b0);
        send_frame(1, 0, 1'b0);
        wbuf[0] = 16'h1111;
        wbuf[1] = 16'h2222;
        wbuf[2] = 16'h3333;
        wbuf[3] = 16'h4444;
        send_frame(1, 4, 1'b0);
        send_frame(1, 1, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        chk("wr_queue_drained", exp_wr_q.size(), 0);
        chk("ev_queue_drained", exp_ev_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
